wall_collision_detect: RTL and testbench
========================================

# wall_collision_detect

Per-frame wall collision detector feeding the `collision` input of the player sprite motion block. During each active frame it scans the background pixel stream for wall-coloured pixels in a one-pixel probe line just ahead of the sprite, in the direction given by the held key. At the last visible pixel it commits a single registered `collision` flag, which stays stable across the following `frame_clk` (vsync) edge when the sprite moves.

## Interface
- `STEP`, 2: sprite move step in pixels; the probe line sits this far beyond the sprite edge.
- `HIT_MIN`, 4: minimum wall-pixel count on the probe line that asserts collision.
- `WALL_R`/`WALL_G`/`WALL_B`, 4'h0/4'h0/4'hF: background RGB treated as wall.
- `Clk` in 1: pixel clock; the only clock.
- `Reset` in 1: asynchronous, active-high.
- `blank` in 1: 1 means an active-video pixel is present this cycle.
- `DrawX`, `DrawY` in 10 each: current pixel coordinate, 0..639 and 0..479.
- `red`, `green`, `blue` in 4 each: background colour at (`DrawX`, `DrawY`), aligned in the same cycle.
- `keycode` in 8: held key.
- `spriteX`, `spriteY`, `spriteS` in 10 each: sprite centre and half-size.
- `collision` out 1: registered; the committed result of the last complete frame.
- `hit_count` out 8: registered; the committed saturating wall-pixel count (debug).

## Operation
- **FSM states:** WAIT_SOF, SCAN, COMMIT.
- **Reset:** `collision`=0, `hit_count`=0, accumulator=0, `edge_hit`=0, dir=NONE, state=WAIT_SOF.
- **SOF definition:** `blank`=1 and `DrawX`=0 and `DrawY`=0.
- **SOF latch:** in any state, SOF latches `keycode`→dir, latches `spriteX`/`spriteY`/`spriteS`, clears the accumulator, computes `edge_hit`, and enters SCAN.
  - Key mapping: 8'h04→LEFT, 8'h07→RIGHT, 8'h1A→UP, 8'h16→DOWN, any other value→NONE.
- **Probe line**, computed in 11-bit signed arithmetic so that no value wraps:
  - LEFT: x = sX−sS−STEP, with y in [sY−sS, sY+sS].
  - RIGHT: x = sX+sS+STEP, with the same y range.
  - UP: y = sY−sS−STEP, with x in [sX−sS, sX+sS].
  - DOWN: y = sY+sS+STEP, with the same x range.
- **Screen-edge hit:** `edge_hit`=1 when the probe line coordinate is <0, or >639 (x) / >479 (y).
- **Counting in SCAN:** a pixel counts when `blank`=1, it lies on the probe line, and RGB equals WALL. This match is registered (one pipeline stage). On the next cycle the accumulator increments, saturating at 255.
- **End of frame:** the cycle presenting (639,479) with `blank`=1 moves the FSM to COMMIT.
- **COMMIT:** lasts one cycle, which lets the final pipelined match land. Then:
  - `hit_count` ← accumulator.
  - `collision` ← (dir≠NONE) & (`edge_hit` | accumulator ≥ `HIT_MIN`).
  - Next state is WAIT_SOF.
- **SOF arriving in SCAN before (639,479):** the frame is aborted. The FSM restarts with a fresh latch and `collision` keeps its old value.
- **Mid-frame inputs:** changes to `keycode` or sprite inputs during a frame have no effect until the next SOF.

## Timing
- The `collision`/`hit_count` update is visible 2 `Clk` cycles after the (639,479) pixel, well before vsync.
- Both outputs are constant between commits.
- The first frame after `Reset` deasserts mid-frame is ignored. The first commit follows the first full SOF→(639,479) scan.
- Latency from a wall appearing in the probe line to `collision`=1 is at most one frame.

## Structure
- The shared package `game_pkg` holds:
  - `dir_t` enum: NONE, LEFT, RIGHT, UP, DOWN.
  - `KEY_A`/`KEY_D`/`KEY_W`/`KEY_S` keycode constants.
  - `H_LAST`=639 and `V_LAST`=479.
- The natural sub-module is `probe_line_gen`: combinational. It takes dir, the latched sprite values and `STEP`, and outputs the probe bounds and `edge_hit`.
- The FSM, pipeline register and accumulator live in the top module.

## Test plan
- **Reset mid-frame:** assert `Reset` at (100,200) → `collision`=0, `hit_count`=0; no commit until a full frame has run.
- **Wall to the right:** sprite (320,240,30), key 8'h07, wall at x=352 for y 210..270 → after the frame, `hit_count`=61, `collision`=1.
- **Wall on the wrong side:** same wall, key 8'h04 → `hit_count`=0, `collision`=0.
- **Screen edge:** sprite (30,240,30), key 8'h04 (probe x=−2) → `collision`=1 with `hit_count`=0. The same sprite with key 8'h00 → `collision`=0.
- **Below threshold:** 3 wall pixels on the probe line with `HIT_MIN`=4 → `collision`=0, `hit_count`=3. With 300 pixels (long wall, vertical sprite size scaled) → `hit_count`=255, saturated.
- **Abort and mid-frame change:** inject SOF at (0,0) mid-scan → `collision` holds its old value. Changing `keycode` at (0,300) leaves the current frame's dir unchanged.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the sprite/background blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        UP    = 3'd3,
        DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        SCAN     = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;

    localparam logic [9:0] H_LAST = 10'd639;
    localparam logic [9:0] V_LAST = 10'd479;

    // pos is the fixed coordinate of the line; lo/hi bound the other axis.
    // All three hold 11-bit two's-complement values.
    typedef struct packed {
        logic        valid;
        logic        is_col;
        logic [10:0] pos;
        logic [10:0] lo;
        logic [10:0] hi;
    } probe_t;

    function automatic dir_t key_to_dir(input logic [7:0] key);
        dir_t d;
        case (key)
            KEY_A:   d = LEFT;
            KEY_D:   d = RIGHT;
            KEY_W:   d = UP;
            KEY_S:   d = DOWN;
            default: d = NONE;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/probe_line_gen.sv
`default_nettype none
// ============================================================================
// Module      : probe_line_gen
// Description : Combinational probe-line bounds and screen-edge hit for a move.
// Revision    : 1.0 - initial release
// ============================================================================
module probe_line_gen
    import game_pkg::*;
#(
    parameter int STEP = 2
) (
    input  dir_t       i_dir,
    input  logic [9:0] i_sprite_x,
    input  logic [9:0] i_sprite_y,
    input  logic [9:0] i_sprite_s,
    output probe_t     o_probe,
    output logic       o_edge_hit
);

    localparam logic signed [10:0] X_MAX = signed'({1'b0, H_LAST});
    localparam logic signed [10:0] Y_MAX = signed'({1'b0, V_LAST});

    logic signed [10:0] w_sx;
    logic signed [10:0] w_sy;
    logic signed [10:0] w_ss;
    logic signed [10:0] w_step;
    logic signed [10:0] w_pos;
    logic signed [10:0] w_lo;
    logic signed [10:0] w_hi;
    logic               w_valid;
    logic               w_is_col;

    assign w_sx   = signed'({1'b0, i_sprite_x});
    assign w_sy   = signed'({1'b0, i_sprite_y});
    assign w_ss   = signed'({1'b0, i_sprite_s});
    assign w_step = 11'(STEP);

    always_comb begin
        w_valid  = 1'b0;
        w_is_col = 1'b0;
        w_pos    = '0;
        w_lo     = '0;
        w_hi     = '0;
        case (i_dir)
            LEFT: begin
                w_valid  = 1'b1;
                w_is_col = 1'b1;
                w_pos    = w_sx - w_ss - w_step;
                w_lo     = w_sy - w_ss;
                w_hi     = w_sy + w_ss;
            end
            RIGHT: begin
                w_valid  = 1'b1;
                w_is_col = 1'b1;
                w_pos    = w_sx + w_ss + w_step;
                w_lo     = w_sy - w_ss;
                w_hi     = w_sy + w_ss;
            end
            UP: begin
                w_valid  = 1'b1;
                w_pos    = w_sy - w_ss - w_step;
                w_lo     = w_sx - w_ss;
                w_hi     = w_sx + w_ss;
            end
            DOWN: begin
                w_valid  = 1'b1;
                w_pos    = w_sy + w_ss + w_step;
                w_lo     = w_sx - w_ss;
                w_hi     = w_sx + w_ss;
            end
            default: ;
        endcase
    end

    // A probe line off-screen means the sprite would leave the visible area.
    always_comb begin
        o_edge_hit = 1'b0;
        if (w_valid) begin
            o_edge_hit = (w_pos < 11'sd0) ||
                         (w_is_col ? (w_pos > X_MAX) : (w_pos > Y_MAX));
        end
    end

    assign o_probe = '{valid:  w_valid,
                       is_col: w_is_col,
                       pos:    w_pos,
                       lo:     w_lo,
                       hi:     w_hi};

endmodule
`default_nettype wire

// File: rtl/wall_collision_detect.sv
`default_nettype none
// ============================================================================
// Module      : wall_collision_detect
// Description : Per-frame wall-pixel scan ahead of the sprite; commits collision.
// Revision    : 1.0 - initial release
// ============================================================================
module wall_collision_detect
    import game_pkg::*;
#(
    parameter int         STEP    = 2,
    parameter int         HIT_MIN = 4,
    parameter logic [3:0] WALL_R  = 4'h0,
    parameter logic [3:0] WALL_G  = 4'h0,
    parameter logic [3:0] WALL_B  = 4'hF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       blank,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    input  logic [7:0] keycode,
    input  logic [9:0] spriteX,
    input  logic [9:0] spriteY,
    input  logic [9:0] spriteS,
    output logic       collision,
    output logic [7:0] hit_count
);

    state_t             r_state;
    state_t             w_state_next;
    dir_t               r_dir;
    probe_t             r_probe;
    logic               r_edge_hit;
    logic               r_match;
    logic [7:0]         r_acc;
    logic               r_collision;
    logic [7:0]         r_hit_count;

    dir_t               w_key_dir;
    probe_t             w_probe;
    logic               w_edge_hit;
    logic               w_sof;
    logic               w_eof;
    logic signed [10:0] w_px;
    logic signed [10:0] w_py;
    logic               w_on_line;
    logic               w_wall;
    logic               w_match;
    logic [7:0]         w_acc_next;
    logic               w_commit;

    assign w_sof = blank && (DrawX == 10'd0) && (DrawY == 10'd0);
    assign w_eof = blank && (DrawX == H_LAST) && (DrawY == V_LAST);

    // The probe is derived from the live inputs and captured only at SOF,
    // which freezes the direction and sprite geometry for the whole frame.
    assign w_key_dir = key_to_dir(keycode);

    probe_line_gen #(
        .STEP (STEP)
    ) u_probe_line_gen (
        .i_dir      (w_key_dir),
        .i_sprite_x (spriteX),
        .i_sprite_y (spriteY),
        .i_sprite_s (spriteS),
        .o_probe    (w_probe),
        .o_edge_hit (w_edge_hit)
    );

    assign w_px = signed'({1'b0, DrawX});
    assign w_py = signed'({1'b0, DrawY});

    always_comb begin
        w_on_line = 1'b0;
        if (r_probe.valid) begin
            if (r_probe.is_col) begin
                w_on_line = (w_px == signed'(r_probe.pos)) &&
                            (w_py >= signed'(r_probe.lo))  &&
                            (w_py <= signed'(r_probe.hi));
            end else begin
                w_on_line = (w_py == signed'(r_probe.pos)) &&
                            (w_px >= signed'(r_probe.lo))  &&
                            (w_px <= signed'(r_probe.hi));
            end
        end
    end

    assign w_wall  = (red == WALL_R) && (green == WALL_G) && (blue == WALL_B);
    assign w_match = (r_state == SCAN) && !w_sof && blank && w_on_line && w_wall;

    assign w_acc_next = (r_match && (r_acc != 8'hFF)) ? r_acc + 8'd1 : r_acc;

    // Commit sees the accumulator including the last pipelined match.
    assign w_commit = (r_dir != NONE) &&
                      (r_edge_hit || (int'(w_acc_next) >= HIT_MIN));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_SOF: if (w_sof) w_state_next = SCAN;
            SCAN: begin
                if (w_sof) begin
                    w_state_next = SCAN;
                end else if (w_eof) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT:   w_state_next = w_sof ? SCAN : WAIT_SOF;
            default:  w_state_next = WAIT_SOF;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_dir       <= NONE;
            r_probe     <= '0;
            r_edge_hit  <= 1'b0;
            r_match     <= 1'b0;
            r_acc       <= '0;
            r_collision <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_match <= w_match;
            if (w_sof) begin
                r_dir      <= w_key_dir;
                r_probe    <= w_probe;
                r_edge_hit <= w_edge_hit;
                r_acc      <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
            if (r_state == COMMIT) begin
                r_hit_count <= w_acc_next;
                r_collision <= w_commit;
            end
        end
    end

    assign collision = r_collision;
    assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_wall_collision_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_wall_collision_detect
// Description : Scoreboarded frame-level bench for wall_collision_detect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wall_collision_detect;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       blank;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic [7:0] keycode;
    logic [9:0] spriteX;
    logic [9:0] spriteY;
    logic [9:0] spriteS;
    logic       collision;
    logic [7:0] hit_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Wall rectangle painted into the background (empty when wx0 > wx1).
    int wx0 = 1, wx1 = 0, wy0 = 1, wy1 = 0;

    typedef struct {
        string tag;
        int    cnt;
        int    coll;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    wall_collision_detect #(
        .STEP    (2),
        .HIT_MIN (4),
        .WALL_R  (4'h0),
        .WALL_G  (4'h0),
        .WALL_B  (4'hF)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .blank     (blank),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .keycode   (keycode),
        .spriteX   (spriteX),
        .spriteY   (spriteY),
        .spriteS   (spriteS),
        .collision (collision),
        .hit_count (hit_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Non-wall pixels rotate through near-miss colours.
    task automatic drive_pix(input int x, input int y, input bit act);
        blank = act;
        DrawX = 10'(x);
        DrawY = 10'(y);
        if (x >= wx0 && x <= wx1 && y >= wy0 && y <= wy1) begin
            {red, green, blue} = 12'h00F;
        end else begin
            case (y % 3)
                0:       {red, green, blue} = 12'h10F;
                1:       {red, green, blue} = 12'h01F;
                default: {red, green, blue} = 12'h00E;
            endcase
        end
        tick();
    endtask

    task automatic start_frame(input logic [7:0] key, input int sx, input int sy, input int ss);
        keycode = key;
        spriteX = 10'(sx);
        spriteY = 10'(sy);
        spriteS = 10'(ss);
        drive_pix(0, 0, 1'b1);
        keycode = 8'($urandom);
        spriteX = 10'($urandom_range(0, 639));
        spriteY = 10'($urandom_range(0, 479));
        spriteS = 10'($urandom_range(0, 200));
    endtask

    // Each row is shown visible, then repeated with blank low.
    task automatic scan(input int xa, input int xb, input int ya, input int yb);
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                if (!(x == 0 && y == 0) && !(x == 639 && y == 479)) drive_pix(x, y, 1'b1);
            end
            for (int x = xa; x <= xb; x++) begin
                drive_pix(x, y, 1'b0);
            end
        end
    endtask

    task automatic end_frame();
        drive_pix(639, 479, 1'b1);
        blank = 1'b0;
        tick();
    endtask

    task automatic expect_push(input string tag, input int cnt, input int coll);
        exp_t e;
        e.tag  = tag;
        e.cnt  = cnt;
        e.coll = coll;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, "_cnt"},  32'(hit_count), 32'(e.cnt));
            check_eq({e.tag, "_coll"}, 32'(collision), 32'(e.coll));
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] key,
                             input int sx, input int sy, input int ss,
                             input int xa, input int xb, input int ya, input int yb,
                             input int cnt, input int coll);
        expect_push(tag, cnt, coll);
        start_frame(key, sx, sy, ss);
        scan(xa, xb, ya, yb);
        end_frame();
        sb_check();
    endtask

    task automatic set_wall(input int x0, input int x1, input int y0, input int y1);
        wx0 = x0; wx1 = x1; wy0 = y0; wy1 = y1;
    endtask

    initial begin
        Reset   = 1'b1;
        blank   = 1'b0;
        DrawX   = '0;
        DrawY   = '0;
        {red, green, blue} = '0;
        keycode = '0;
        spriteX = '0;
        spriteY = '0;
        spriteS = '0;
        tick();
        tick();
        check_eq("reset_coll", 32'(collision), 32'd0);
        check_eq("reset_cnt",  32'(hit_count), 32'd0);
        Reset = 1'b0;
        tick();

        set_wall(352, 352, 210, 270);
        run_frame("right", 8'h07, 320, 240, 30, 350, 354, 200, 280, 61, 1);

        // Reset mid-frame: no commit until a full SOF-to-end scan.
        start_frame(8'h07, 320, 240, 30);
        scan(350, 354, 200, 230);
        Reset = 1'b1;
        drive_pix(100, 200, 1'b1);
        check_eq("midrst_coll", 32'(collision), 32'd0);
        check_eq("midrst_cnt",  32'(hit_count), 32'd0);
        Reset = 1'b0;
        scan(350, 354, 231, 280);
        expect_push("norun", 0, 0);
        end_frame();
        sb_check();

        run_frame("right2", 8'h07, 320, 240, 30, 350, 354, 200, 280, 61, 1);
        run_frame("left",   8'h04, 320, 240, 30, 350, 354, 200, 280, 0, 0);
        run_frame("right3", 8'h07, 320, 240, 30, 350, 354, 200, 280, 61, 1);

        set_wall(1, 0, 1, 0);
        run_frame("edge_left",  8'h04, 30, 240, 30, 20, 40, 200, 210, 0, 1);
        run_frame("edge_none",  8'h00, 30, 240, 30, 20, 40, 200, 210, 0, 0);
        run_frame("edge_right", 8'h07, 620, 240, 30, 600, 620, 200, 210, 0, 1);
        run_frame("left_open",  8'h04, 320, 240, 30, 286, 290, 230, 240, 0, 0);
        run_frame("edge_top",   8'h1A, 320, 20, 30, 300, 320, 1, 5, 0, 1);

        set_wall(352, 352, 240, 242);
        run_frame("below_min", 8'h07, 320, 240, 30, 350, 354, 230, 250, 3, 0);
        set_wall(352, 352, 240, 243);
        run_frame("at_min",    8'h07, 320, 240, 30, 350, 354, 230, 250, 4, 1);

        set_wall(472, 472, 0, 479);
        run_frame("saturate",  8'h07, 320, 240, 150, 471, 473, 0, 479, 255, 1);

        set_wall(300, 309, 208, 208);
        run_frame("up",   8'h1A, 320, 240, 30, 280, 360, 206, 210, 10, 1);
        set_wall(200, 400, 272, 272);
        run_frame("down", 8'h16, 320, 240, 30, 280, 360, 270, 274, 61, 1);

        // Abort by an early SOF, then a key change mid-frame.
        set_wall(352, 352, 210, 270);
        run_frame("pre_abort", 8'h07, 320, 240, 30, 350, 354, 200, 280, 61, 1);
        start_frame(8'h07, 320, 240, 30);
        scan(350, 354, 200, 240);
        start_frame(8'h04, 320, 240, 30);
        tick();
        check_eq("abort_cnt",  32'(hit_count), 32'd61);
        check_eq("abort_coll", 32'(collision), 32'd1);
        scan(350, 354, 200, 299);
        keycode = 8'h07;
        drive_pix(0, 300, 1'b1);
        scan(350, 354, 301, 305);
        expect_push("key_change", 0, 0);
        end_frame();
        sb_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
